// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg : shared state type, 7-segment table and BCD helper
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int C_MAX_DIGITS = 6;

  // Active-high segment patterns (a..g on bits 0..6); non-decimal codes are dark.
  localparam logic [6:0] C_SEG_ENC [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

  localparam logic [6:0] C_SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    return C_SEG_ENC[digit];
  endfunction

  function automatic logic [4*C_MAX_DIGITS-1:0] to_bcd(input int unsigned value);
    logic [4*C_MAX_DIGITS-1:0] result;
    int unsigned               rest;
    result = '0;
    rest   = value;
    for (int i = 0; i < C_MAX_DIGITS; i++) begin
      result[4*i +: 4] = 4'(rest % 10);
      rest             = rest / 10;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/countdown_timer_mux_if.sv
// ---------------------------------------------------------------------------
// countdown_timer_mux_if : buttons, mode and display/LED bundle of the timer
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface countdown_timer_mux_if #(
  parameter int DIGITS = 2,
  parameter int LED_N  = 6
);

  logic              i_btn_start;
  logic              i_btn_reset;
  logic              i_mode;
  logic [6:0]        o_seg;
  logic [DIGITS-1:0] o_dig_en;
  logic [LED_N-1:0]  o_led;
  logic              o_running;
  logic              o_done;

  modport master (
    output i_btn_start, i_btn_reset, i_mode,
    input  o_seg, o_dig_en, o_led, o_running, o_done
  );

  modport slave (
    input  i_btn_start, i_btn_reset, i_mode,
    output o_seg, o_dig_en, o_led, o_running, o_done
  );

endinterface

`default_nettype wire

// File: rtl/seven_seg_scan.sv
// ---------------------------------------------------------------------------
// seven_seg_scan : time-multiplexed common-segment driver, registered outputs
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seven_seg_scan
  import timer_pkg::*;
#(
  parameter int         DIGITS  = 2,
  parameter int         SCAN    = 1,
  parameter logic [6:0] RST_SEG = 7'h7F
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [4*DIGITS-1:0] i_bcd,
  input  logic [DIGITS-1:0]   i_blank,
  output logic [6:0]          o_seg,
  output logic [DIGITS-1:0]   o_dig_en
);

  localparam int C_CW = (SCAN > 1) ? $clog2(SCAN) : 1;
  localparam int C_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [C_CW-1:0] r_cnt;
  logic [C_IW-1:0] r_idx;
  logic            w_slot_end;
  logic [C_IW-1:0] w_next_idx;
  logic [3:0]      w_digit;
  logic [6:0]      w_seg_next;

  always_comb begin
    w_slot_end = (r_cnt == C_CW'(SCAN - 1));
    w_next_idx = r_idx;
    if (w_slot_end) begin
      w_next_idx = (r_idx == C_IW'(DIGITS - 1)) ? '0 : r_idx + C_IW'(1);
    end
    w_digit    = i_bcd[4*w_next_idx +: 4];
    w_seg_next = i_blank[w_next_idx] ? C_SEG_BLANK : ~seg_encode(w_digit);
  end

  // Segment pattern and enable are both derived from the next index so they switch together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      o_seg    <= RST_SEG;
      o_dig_en <= DIGITS'(1);
    end else begin
      r_cnt    <= w_slot_end ? '0 : r_cnt + C_CW'(1);
      r_idx    <= w_next_idx;
      o_seg    <= w_seg_next;
      o_dig_en <= DIGITS'(1) << w_next_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/countdown_timer_mux.sv
// ---------------------------------------------------------------------------
// countdown_timer_mux : BCD up/down timer with run/pause FSM, muxed display, alarm LEDs
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module countdown_timer_mux
  import timer_pkg::*;
#(
  parameter int CLK_HZ   = 27000000,
  parameter int TICK_HZ  = 1,
  parameter int DIGITS   = 2,
  parameter int PRESET   = 59,
  parameter int MUX_HZ   = 90,
  parameter int LED_N    = 6,
  parameter int BLINK    = 1,
  parameter int BLANK_LZ = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  countdown_timer_mux_if.slave bus
);

  localparam int C_DIV      = CLK_HZ / TICK_HZ;
  localparam int C_PW       = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam int C_SCAN_RAW = CLK_HZ / (MUX_HZ * DIGITS);
  localparam int C_SCAN     = (C_SCAN_RAW < 1) ? 1 : C_SCAN_RAW;
  localparam int C_BW       = 4 * DIGITS;

  localparam logic [4*C_MAX_DIGITS-1:0] C_PRESET_ALL = to_bcd(PRESET);
  localparam logic [C_BW-1:0]           C_PRESET_BCD = C_PRESET_ALL[C_BW-1:0];
  localparam logic [6:0]                C_RST_SEG    = ~seg_encode(C_PRESET_ALL[3:0]);
  localparam logic [C_PW-1:0]           C_PRESC_LAST = C_PW'(C_DIV - 1);

  state_t            r_state;
  logic              r_mode;
  logic [C_BW-1:0]   r_count;
  logic [C_PW-1:0]   r_presc;
  logic [LED_N-1:0]  r_led;
  logic              r_running;
  logic              r_done;
  logic              r_start_smp, r_start_prev;
  logic              r_reset_smp, r_reset_prev;

  logic              w_start_edge, w_reset_edge, w_wrap;
  logic [C_BW-1:0]   w_load, w_tv, w_inc, w_dec, w_next;
  logic [DIGITS-1:0] w_blank;

  assign w_start_edge = r_start_smp & ~r_start_prev;
  assign w_reset_edge = r_reset_smp & ~r_reset_prev;
  assign w_wrap       = (r_presc == C_PRESC_LAST);
  assign w_load       = bus.i_mode ? '0 : C_PRESET_BCD;
  assign w_tv         = r_mode ? C_PRESET_BCD : '0;

  always_comb begin
    logic carry;
    logic borrow;
    w_inc  = r_count;
    w_dec  = r_count;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
      if (borrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
    // Already at terminal (e.g. PRESET of 0) means the next tick just confirms it.
    w_next = (r_count == w_tv) ? w_tv : (r_mode ? w_inc : w_dec);
  end

  always_comb begin
    logic lead;
    w_blank = '0;
    lead    = (BLANK_LZ != 0);
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && (r_count[4*i +: 4] == 4'd0)) begin
        w_blank[i] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_start_smp  <= 1'b0;
      r_start_prev <= 1'b0;
      r_reset_smp  <= 1'b0;
      r_reset_prev <= 1'b0;
      r_state      <= ST_IDLE;
      r_mode       <= 1'b0;
      r_count      <= C_PRESET_BCD;
      r_presc      <= '0;
      r_led        <= '1;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_start_smp  <= bus.i_btn_start;
      r_start_prev <= r_start_smp;
      r_reset_smp  <= bus.i_btn_reset;
      r_reset_prev <= r_reset_smp;
      if (w_reset_edge) begin
        r_state   <= ST_IDLE;
        r_mode    <= bus.i_mode;
        r_count   <= w_load;
        r_presc   <= '0;
        r_led     <= '1;
        r_running <= 1'b0;
        r_done    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_mode  <= bus.i_mode;
            r_count <= w_load;
            r_presc <= '0;
            if (w_start_edge) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_start_edge) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end else if (w_wrap) begin
              r_presc <= '0;
              r_count <= w_next;
              if (w_next == w_tv) begin
                r_state   <= ST_DONE;
                r_running <= 1'b0;
                r_done    <= 1'b1;
                r_led     <= '0;
              end
            end else begin
              r_presc <= r_presc + C_PW'(1);
            end
          end
          ST_PAUSE: begin
            if (w_start_edge) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_DONE: begin
            if (w_wrap) begin
              r_presc <= '0;
              if (BLINK != 0) r_led <= ~r_led;
            end else begin
              r_presc <= r_presc + C_PW'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.o_led     = r_led;
  assign bus.o_running = r_running;
  assign bus.o_done    = r_done;

  seven_seg_scan #(
    .DIGITS  (DIGITS),
    .SCAN    (C_SCAN),
    .RST_SEG (C_RST_SEG)
  ) u_scan (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_bcd    (r_count),
    .i_blank  (w_blank),
    .o_seg    (bus.o_seg),
    .o_dig_en (bus.o_dig_en)
  );

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_mux.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer_mux : directed bench for countdown_timer_mux (100 Hz clock model)
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_countdown_timer_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n, n2, p, q, s, u, e, r;
  logic [1:0] prev_en;
  bit         synced;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  countdown_timer_mux_if #(.DIGITS(2), .LED_N(6)) bus ();

  countdown_timer_mux #(
    .CLK_HZ   (100),
    .TICK_HZ  (1),
    .DIGITS   (2),
    .PRESET   (59),
    .MUX_HZ   (25),
    .LED_N    (6),
    .BLINK    (1),
    .BLANK_LZ (1)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic at_edge(input int edge_no);
    while (cyc < edge_no) @(negedge clk);
  endtask

  // Called at a negedge; the following posedge samples the buttons and is returned.
  task automatic press(input logic start, input logic rst_btn, output int sample_edge);
    bus.i_btn_start = start;
    bus.i_btn_reset = rst_btn;
    @(negedge clk);
    sample_edge     = cyc;
    bus.i_btn_start = 1'b0;
    bus.i_btn_reset = 1'b0;
  endtask

  initial begin
    bus.i_btn_start = 1'b0;
    bus.i_btn_reset = 1'b0;
    bus.i_mode      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", dut.r_count, 8'h59);
    check("rst_led", bus.o_led, 6'h3F);
    rst = 1'b0;
    #1;
    check("rst_dig_en", bus.o_dig_en, 2'b01);
    check("rst_seg", bus.o_seg, 7'h18);
    check("rst_running", bus.o_running, 0);
    check("rst_done", bus.o_done, 0);
    @(negedge clk);

    // Down count from 59
    press(1'b1, 1'b0, n);
    at_edge(n + 1);
    check("dn_running", bus.o_running, 1);
    at_edge(n + 100);
    check("dn_pre_step", dut.r_count, 8'h59);
    at_edge(n + 101);
    check("dn_first_step", dut.r_count, 8'h58);

    at_edge(n + 5440);
    check("dn_count05", dut.r_count, 8'h05);
    prev_en = bus.o_dig_en;
    synced  = 1'b0;
    for (int i = 0; i < 6 && !synced; i++) begin
      @(negedge clk);
      if (prev_en == 2'b10 && bus.o_dig_en == 2'b01) synced = 1'b1;
      prev_en = bus.o_dig_en;
    end
    check("scan_sync", synced, 1);
    for (int i = 0; i < 8; i++) begin
      check("scan_en", bus.o_dig_en, ((i / 2) % 2 != 0) ? 2'b10 : 2'b01);
      check("scan_seg", bus.o_seg, ((i / 2) % 2 != 0) ? 7'h7F : 7'h12);
      @(negedge clk);
    end

    at_edge(n + 5900);
    check("dn_count01", dut.r_count, 8'h01);
    check("dn_not_done", bus.o_done, 0);
    at_edge(n + 5901);
    check("dn_done", bus.o_done, 1);
    check("dn_count00", dut.r_count, 8'h00);
    check("dn_run_low", bus.o_running, 0);
    check("dn_led_on", bus.o_led, 6'h00);
    at_edge(n + 5901 + 99);
    check("led_hold", bus.o_led, 6'h00);
    at_edge(n + 5901 + 100);
    check("led_toggle1", bus.o_led, 6'h3F);
    at_edge(n + 5901 + 200);
    check("led_toggle2", bus.o_led, 6'h00);
    press(1'b1, 1'b0, e);
    at_edge(e + 2);
    check("done_ign_start", bus.o_done, 1);
    check("done_ign_run", bus.o_running, 0);

    press(1'b0, 1'b1, r);
    at_edge(r + 1);
    check("rel_done", bus.o_done, 0);
    check("rel_count", dut.r_count, 8'h59);
    check("rel_led", bus.o_led, 6'h3F);

    // Pause at prescaler 40, resume
    @(negedge clk);
    press(1'b1, 1'b0, n2);
    at_edge(n2 + 40);
    press(1'b1, 1'b0, p);
    at_edge(p + 1);
    check("pause_run_low", bus.o_running, 0);
    check("pause_presc", dut.r_presc, 40);
    bus.i_mode = 1'b1;
    at_edge(p + 501);
    check("pause_count", dut.r_count, 8'h59);
    check("pause_presc_hold", dut.r_presc, 40);
    press(1'b1, 1'b0, q);
    at_edge(q + 1);
    check("resume_run", bus.o_running, 1);
    at_edge(q + 60);
    check("resume_pre_step", dut.r_count, 8'h59);
    at_edge(q + 61);
    check("resume_step", dut.r_count, 8'h58);
    bus.i_mode = 1'b0;

    // Start and reset on the same cycle at count 37
    at_edge(q + 2200);
    check("sim_count37", dut.r_count, 8'h37);
    press(1'b1, 1'b1, s);
    check("sim_still_run", bus.o_running, 1);
    at_edge(s + 1);
    check("sim_run_low", bus.o_running, 0);
    check("sim_count", dut.r_count, 8'h59);
    at_edge(s + 3);
    check("sim_stay_idle", bus.o_running, 0);

    // Up count
    bus.i_mode = 1'b1;
    at_edge(cyc + 2);
    check("up_load", dut.r_count, 8'h00);
    press(1'b1, 1'b0, u);
    at_edge(u + 1 + 900);
    check("up_count09", dut.r_count, 8'h09);
    at_edge(u + 1 + 1000);
    check("up_carry10", dut.r_count, 8'h10);
    bus.i_mode = 1'b0;
    at_edge(u + 5900);
    check("up_count58", dut.r_count, 8'h58);
    check("up_running", bus.o_running, 1);
    at_edge(u + 5901);
    check("up_count59", dut.r_count, 8'h59);
    check("up_done", bus.o_done, 1);
    check("up_run_fall", bus.o_running, 0);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_led", bus.o_led, 6'h3F);
    check("arst_done", bus.o_done, 0);
    check("arst_dig_en", bus.o_dig_en, 2'b01);
    check("arst_seg", bus.o_seg, 7'h18);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
